// File: rtl/fpu_div_if.sv
// Operand/result bus for the half-precision divider.
// The master issues operands on a valid_in pulse while ready is high.
// The slave returns a one-cycle valid_out pulse with result and div_by_zero.
interface fpu_div_if;
  logic        valid_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        valid_out;
  logic [15:0] result;
  logic        div_by_zero;

  modport master (output valid_in, a, b,
                  input  ready, valid_out, result, div_by_zero);
  modport slave  (input  valid_in, a, b,
                  output ready, valid_out, result, div_by_zero);
endinterface

// File: rtl/fpu_div.sv
// binary16 divider, result = a / b, one quotient bit per cycle.
// Truncating rounding, denormals flushed to zero.
// Latency is fixed at 16 cycles from issue to valid_out, including special operands.
module fpu_div #(
  parameter logic [15:0] QNAN = 16'h7E00
) (
  input  logic      clk,
  input  logic      rst_n,
  fpu_div_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DECODE, DIVIDE, NORMALIZE, PACK} state_t;

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d, b_q, b_d;
  logic [11:0]        rem_q, rem_d;
  logic [10:0]        mb_q, mb_d;
  logic [11:0]        quo_q, quo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [9:0]         mant_q, mant_d;
  logic signed [6:0]  e_q, e_d;
  logic               vo_q, vo_d;
  logic [15:0]        res_q, res_d;
  logic               dz_q, dz_d;

  // Operand classification, taken from the latched operands (stable until PACK).
  logic [4:0]         ea, eb;
  logic               s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic               ge;
  logic [11:0]        rem_sub;
  logic signed [6:0]  e_base;

  assign ea      = a_q[14:10];
  assign eb      = b_q[14:10];
  assign s       = a_q[15] ^ b_q[15];
  assign nan_a   = (&ea) &  (|a_q[9:0]);
  assign nan_b   = (&eb) &  (|b_q[9:0]);
  assign inf_a   = (&ea) & ~(|a_q[9:0]);
  assign inf_b   = (&eb) & ~(|b_q[9:0]);
  assign zero_a  = ~(|ea);
  assign zero_b  = ~(|eb);

  // Compare before shifting: the first iteration yields the integer bit of
  // ma/mb, the remaining eleven the fraction, so quo = floor(ma*2048/mb).
  assign ge      = rem_q >= {1'b0, mb_q};
  assign rem_sub = rem_q - {1'b0, mb_q};
  assign e_base  = $signed({2'b00, ea}) - $signed({2'b00, eb});

  assign bus.ready       = (state_q == IDLE);
  assign bus.valid_out   = vo_q;
  assign bus.result      = res_q;
  assign bus.div_by_zero = dz_q;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      mant_q  <= '0;
      e_q     <= '0;
      vo_q    <= 1'b0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      e_q     <= e_d;
      vo_q    <= vo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath updates per state; valid_out is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    e_d     = e_q;
    vo_d    = 1'b0;
    res_d   = res_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Hidden bit always set; zero/denormal operands are resolved in PACK.
        rem_d   = {2'b01, a_q[9:0]};
        mb_d    = {1'b1, b_q[9:0]};
        quo_d   = '0;
        cnt_d   = 4'd11;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        rem_d = ge ? {rem_sub[10:0], 1'b0} : {rem_q[10:0], 1'b0};
        quo_d = {quo_q[10:0], ge};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = NORMALIZE;
      end
      NORMALIZE: begin
        if (quo_q[11]) begin
          mant_d = quo_q[10:1];
          e_d    = e_base + 7'sd15;
        end else begin
          mant_d = quo_q[9:0];
          e_d    = e_base + 7'sd14;
        end
        state_d = PACK;
      end
      PACK: begin
        vo_d    = 1'b1;
        dz_d    = 1'b0;
        state_d = IDLE;
        if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b))
          res_d = QNAN;
        else if (zero_b && !inf_a) begin
          res_d = {s, 5'h1F, 10'h000};
          dz_d  = 1'b1;
        end else if (inf_a)
          res_d = {s, 5'h1F, 10'h000};
        else if (zero_a || inf_b)
          res_d = {s, 15'h0000};
        else if (e_q >= 7'sd31)
          res_d = {s, 5'h1F, 10'h000};
        else if (e_q <= 7'sd0)
          res_d = {s, 15'h0000};
        else
          res_d = {s, e_q[4:0], mant_q};
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div: directed vector table, mid-operation reset,
// streaming handshake and random operands against a real-arithmetic model.
module tb_fpu_div;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_div_if bus();

  fpu_div #(.QNAN(16'h7E00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        dz;
    string       nm;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: value = (ma/mb) * 2^(ea-eb), normalised with real arithmetic.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic dz);
    logic s;
    int   ea, eb, fa, fb, k, mi;
    bit   an, bn, ai, bi, az, bz;
    real  q;
    logic [4:0] ex;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    an = (ea == 31) && (fa != 0);
    bn = (eb == 31) && (fb != 0);
    ai = (ea == 31) && (fa == 0);
    bi = (eb == 31) && (fb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    dz = 1'b0;
    if (an || bn || (ai && bi) || (az && bz)) r = 16'h7E00;
    else if (bz && !ai) begin r = {s, 15'h7C00}; dz = 1'b1; end
    else if (ai) r = {s, 15'h7C00};
    else if (az || bi) r = {s, 15'h0000};
    else begin
      q = real'(1024 + fa) / real'(1024 + fb);
      k = ea - eb;
      while (q >= 2.0) begin q = q / 2.0; k++; end
      while (q < 1.0)  begin q = q * 2.0; k--; end
      if (k + 15 >= 31)     r = {s, 15'h7C00};
      else if (k + 15 <= 0) r = {s, 15'h0000};
      else begin
        mi = $rtoi((q - 1.0) * 1024.0);
        ex = 5'(k + 15);
        r  = {s, ex, 10'(mi)};
      end
    end
  endfunction

  function automatic logic [15:0] rnd_normal();
    logic [4:0] e;
    e = 5'($urandom_range(30, 1));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  // Issue one operation and wait (bounded) for its valid_out pulse.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic dz, output int lat);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 0;
    while (!bus.valid_out && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = bus.result;
    dz = bus.div_by_zero;
  endtask

  initial begin
    logic [15:0] r, er, last_res;
    logic        dz, edz;
    int          lat, last, pulses, bad_stab, stray;
    logic [15:0] qa[$], qb[$];
    logic [15:0] ta, tb2;

    bus.valid_in = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_result", 32'(bus.result), 32'h0000);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    vq.push_back('{16'h4600, 16'h4000, 16'h4200, 1'b0, "4600/4000"});
    vq.push_back('{16'h3C00, 16'h4200, 16'h3555, 1'b0, "3C00/4200"});
    vq.push_back('{16'hBC00, 16'h3800, 16'hC000, 1'b0, "BC00/3800"});
    vq.push_back('{16'h3C00, 16'h3C00, 16'h3C00, 1'b0, "3C00/3C00"});
    vq.push_back('{16'h3C00, 16'h0000, 16'h7C00, 1'b1, "3C00/0000"});
    vq.push_back('{16'h0000, 16'h0000, 16'h7E00, 1'b0, "0000/0000"});
    vq.push_back('{16'h7C00, 16'h7C00, 16'h7E00, 1'b0, "7C00/7C00"});
    vq.push_back('{16'h7C01, 16'h3C00, 16'h7E00, 1'b0, "7C01/3C00"});
    vq.push_back('{16'h3C00, 16'hFC00, 16'h8000, 1'b0, "3C00/FC00"});
    vq.push_back('{16'h0000, 16'hC000, 16'h8000, 1'b0, "0000/C000"});
    vq.push_back('{16'h7BFF, 16'h0400, 16'h7C00, 1'b0, "7BFF/0400"});
    vq.push_back('{16'h0400, 16'h7BFF, 16'h0000, 1'b0, "0400/7BFF"});
    vq.push_back('{16'h0200, 16'h3C00, 16'h0000, 1'b0, "0200/3C00"});
    vq.push_back('{16'h7C00, 16'hC000, 16'hFC00, 1'b0, "7C00/C000"});

    foreach (vq[i]) begin
      run_op(vq[i].a, vq[i].b, r, dz, lat);
      chk({vq[i].nm, " result"}, 32'(r), 32'(vq[i].r));
      chk({vq[i].nm, " dz"}, 32'(dz), 32'(vq[i].dz));
      chk({vq[i].nm, " latency"}, 32'(lat), 32'd15);
      @(posedge clk); #1;
      chk({vq[i].nm, " pulse_end"}, 32'(bus.valid_out), 32'd0);
    end

    // Streaming: valid_in held high, operands change every cycle.
    last = -1; pulses = 0; bad_stab = 0; last_res = '0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      bus.valid_in = 1'b1; bus.a = rnd_normal(); bus.b = rnd_normal();
      if (bus.ready) begin qa.push_back(bus.a); qb.push_back(bus.b); end
      @(posedge clk); #1;
      if (bus.valid_out) begin
        if (qa.size() == 0) chk("hs_unexpected_pulse", 32'd1, 32'd0);
        else begin
          ta = qa.pop_front(); tb2 = qb.pop_front();
          ref_div(ta, tb2, er, edz);
          chk("hs_result", 32'(bus.result), 32'(er));
          chk("hs_dz", 32'(bus.div_by_zero), 32'(edz));
        end
        if (last >= 0) chk("hs_interval", 32'(c - last), 32'd16);
        last = c; pulses++; last_res = bus.result;
      end else if (last >= 0 && bus.result !== last_res) bad_stab++;
    end
    @(negedge clk) bus.valid_in = 1'b0;
    chk("hs_stable", 32'(bad_stab), 32'd0);
    chk("hs_pulses", 32'(pulses), 32'd4);
    repeat (20) @(posedge clk);

    // Random normal-range operands.
    for (int i = 0; i < 1000; i++) begin
      ta = rnd_normal(); tb2 = rnd_normal();
      ref_div(ta, tb2, er, edz);
      run_op(ta, tb2, r, dz, lat);
      if (r !== er || dz !== edz || lat != 15)
        $display("info: a=%h b=%h", ta, tb2);
      chk("rnd_result", 32'(r), 32'(er));
      chk("rnd_dz", 32'(dz), 32'(edz));
      chk("rnd_latency", 32'(lat), 32'd15);
    end

    // Reset in the middle of DIVIDE aborts the operation.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.a = 16'h3C00; bus.b = 16'h4200;
    @(posedge clk); #1 bus.valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'h0000);
    chk("midrst_dz", 32'(bus.div_by_zero), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.valid_out) stray++;
    end
    chk("midrst_no_stray", 32'(stray), 32'd0);
    chk("midrst_result_after", 32'(bus.result), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
